// File: rtl/btn_event_decoder_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_decoder_pkg
//   Shared definitions for the button event decoder slice: FSM state
//   encodings (3-bit), the LED click counter width and a wrapping counter
//   increment helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package btn_event_decoder_pkg;

   // Gesture classifier states; encodings are fixed so other button
   // consumers can decode a probed state value consistently.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRESSED   = 3'd1,
      ST_LONG_HELD = 3'd2,
      ST_WAIT_GAP  = 3'd3,
      ST_DC_HELD   = 3'd4
   } btn_state_e;

   // Width of the click counter that drives LED[5:0]
   localparam int unsigned LED_CNT_W = 6;

   // Click counter increment; wraps 63 -> 0 by construction (no saturation)
   function automatic logic [LED_CNT_W-1:0] click_count_inc(input logic [LED_CNT_W-1:0] cnt);
      return cnt + 6'd1;
   endfunction

endpackage

// File: rtl/btn_event_decoder_edge_detect.sv
// -----------------------------------------------------------------------------
// btn_edge_detect
//   Converts a debounced button level into an "active" (pressed) level and
//   single-cycle combinational rise/fall strobes against a registered copy.
//   Reused by any block that consumes the debounced button.
// Parameters
//   ACTIVE_LOW : 1 -> btn_level==0 means pressed, 0 -> btn_level==1 means pressed
// Ports
//   clk       in  system clock
//   rst       in  asynchronous reset, active-high (prev forced to released)
//   btn_level in  debounced button level, synchronous to clk
//   act       out 1 while the button is pressed (combinational)
//   rise      out released -> pressed transition seen this cycle
//   fall      out pressed -> released transition seen this cycle
// -----------------------------------------------------------------------------
module btn_edge_detect #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_level,
   output logic act,
   output logic rise,
   output logic fall
);

   logic act_s;
   logic prev_r;

   assign act_s = btn_level ^ ACTIVE_LOW;

   // Previous active level; resetting to "released" makes a button held
   // through reset show up as a rise on the first clock afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_r <= 1'b0;
      end else begin
         prev_r <= act_s;
      end
   end

   assign act  = act_s;
   assign rise = act_s & ~prev_r;
   assign fall = ~act_s & prev_r;

endmodule

// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
//   Classifies the debounced button level into press/release edges, short
//   click, long press and (optionally) double click, and counts short clicks
//   on a wrapping 6-bit counter for the LEDs. All event outputs are
//   registered one-cycle pulses; held and click_count are registered levels.
// Configuration
//   BTN_DOUBLE_CLICK_EN defined   : after a short press, wait up to GAP_CYCLES
//                                   for a second press (double_click) before
//                                   declaring a short_click.
//   BTN_DOUBLE_CLICK_EN undefined : short_click fires on the release edge,
//                                   double_click is constant 0, GAP_CYCLES unused.
// Parameters
//   ACTIVE_LOW  : 1 -> btn_level==0 means pressed
//   LONG_CYCLES : pressed cycles before long_press (>=2)
//   GAP_CYCLES  : max released cycles between the clicks of a double click (>=2)
//   CNT_W       : timer width, 2**CNT_W > max(LONG_CYCLES, GAP_CYCLES)
// Ports
//   clk           in  system clock
//   rst           in  asynchronous reset, active-high
//   btn_level     in  debounced button level
//   press_pulse   out pulse on every released->pressed transition
//   release_pulse out pulse on every pressed->released transition
//   short_click   out pulse for a single click shorter than LONG_CYCLES
//   long_press    out pulse when a hold reaches LONG_CYCLES
//   double_click  out pulse on the second press of a double click
//   held          out level, button currently pressed
//   click_count   out short_click counter (wraps), drives LED[5:0]
// -----------------------------------------------------------------------------
module btn_event_decoder
   import btn_event_decoder_pkg::*;
#(
   parameter bit          ACTIVE_LOW  = 1'b1,
   parameter int unsigned LONG_CYCLES = 27_000_000,
   parameter int unsigned GAP_CYCLES  = 8_100_000,
   parameter int unsigned CNT_W       = 25
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 btn_level,
   output logic                 press_pulse,
   output logic                 release_pulse,
   output logic                 short_click,
   output logic                 long_press,
   output logic                 double_click,
   output logic                 held,
   output logic [LED_CNT_W-1:0] click_count
);

   // Last timer value of a hold; reaching it while still pressed is a long press
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_DOUBLE_CLICK_EN
   // Last released cycle in which a second press still counts as a double click
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif

   logic                 act_s;
   logic                 rise_s;
   logic                 fall_s;

   btn_state_e           state_r;
   btn_state_e           state_nxt_s;
   logic [CNT_W-1:0]     timer_r;
   logic [CNT_W-1:0]     timer_nxt_s;

   logic                 short_nxt_s;
   logic                 long_nxt_s;
   logic                 dbl_nxt_s;

   logic                 press_r;
   logic                 release_r;
   logic                 short_r;
   logic                 long_r;
   logic                 dbl_r;
   logic                 held_r;
   logic [LED_CNT_W-1:0] count_r;

   btn_edge_detect #(
      .ACTIVE_LOW (ACTIVE_LOW)
   ) u_edge (
      .clk       (clk),
      .rst       (rst),
      .btn_level (btn_level),
      .act       (act_s),
      .rise      (rise_s),
      .fall      (fall_s)
   );

   // Next-state, timer and event decode for the gesture classifier.
   // The timer is cleared on every state change so it never passes the
   // threshold of the state it is timing.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      short_nxt_s = 1'b0;
      long_nxt_s  = 1'b0;
      dbl_nxt_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            timer_nxt_s = {CNT_W{1'b0}};
            if (rise_s) begin
               state_nxt_s = ST_PRESSED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PRESSED: begin
            // A fall on the threshold cycle still counts as a short press
            if (fall_s) begin
               timer_nxt_s = {CNT_W{1'b0}};
`ifdef BTN_DOUBLE_CLICK_EN
               state_nxt_s = ST_WAIT_GAP;
`else
               short_nxt_s = 1'b1;
               state_nxt_s = ST_IDLE;
`endif
            end else if (timer_r == LONG_LAST) begin
               long_nxt_s  = 1'b1;
               timer_nxt_s = {CNT_W{1'b0}};
               state_nxt_s = ST_LONG_HELD;
            end else begin
               timer_nxt_s = timer_r + CNT_W'(1'b1);
            end
         end
         ST_LONG_HELD: begin
            // A long hold never turns into a click
            timer_nxt_s = {CNT_W{1'b0}};
            if (fall_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_LONG_HELD;
            end
         end
`ifdef BTN_DOUBLE_CLICK_EN
         ST_WAIT_GAP: begin
            // A second press on the expiry cycle still wins as a double click
            if (rise_s) begin
               dbl_nxt_s   = 1'b1;
               timer_nxt_s = {CNT_W{1'b0}};
               state_nxt_s = ST_DC_HELD;
            end else if (timer_r == GAP_LAST) begin
               short_nxt_s = 1'b1;
               timer_nxt_s = {CNT_W{1'b0}};
               state_nxt_s = ST_IDLE;
            end else begin
               timer_nxt_s = timer_r + CNT_W'(1'b1);
            end
         end
         ST_DC_HELD: begin
            // Second press of a double click: no long detection here
            timer_nxt_s = {CNT_W{1'b0}};
            if (fall_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DC_HELD;
            end
         end
`endif
         default: begin
            timer_nxt_s = {CNT_W{1'b0}};
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and timer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         timer_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         timer_r <= timer_nxt_s;
      end
   end

   // Registered event outputs, held level and the wrapping click counter;
   // all sample on the same edge as the transition they report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_r   <= 1'b0;
         release_r <= 1'b0;
         short_r   <= 1'b0;
         long_r    <= 1'b0;
         dbl_r     <= 1'b0;
         held_r    <= 1'b0;
         count_r   <= {LED_CNT_W{1'b0}};
      end else begin
         press_r   <= rise_s;
         release_r <= fall_s;
         short_r   <= short_nxt_s;
         long_r    <= long_nxt_s;
         dbl_r     <= dbl_nxt_s;
         held_r    <= act_s;
         if (short_nxt_s) begin
            count_r <= click_count_inc(count_r);
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign press_pulse   = press_r;
   assign release_pulse = release_r;
   assign short_click   = short_r;
   assign long_press    = long_r;
   assign double_click  = dbl_r;
   assign held          = held_r;
   assign click_count   = count_r;

endmodule

// File: tb/tb_btn_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_event_decoder
//   Directed, self-checking bench for btn_event_decoder with LONG_CYCLES=10,
//   GAP_CYCLES=5, ACTIVE_LOW=1. Expectations follow whichever build of the
//   double-click feature (BTN_DOUBLE_CLICK_EN) is compiled.
//   Inputs change on the falling edge; outputs are checked on the falling
//   edge after the rising edge that sampled the input.
// -----------------------------------------------------------------------------
module tb_btn_event_decoder;

`ifdef BTN_DOUBLE_CLICK_EN
   localparam bit DC_EN = 1'b1;
`else
   localparam bit DC_EN = 1'b0;
`endif

   // Event vector bit positions: {press, release, short, long, double, held}
   localparam logic [5:0] EV_NONE  = 6'b000000;
   localparam logic [5:0] EV_PRESS = 6'b100000;
   localparam logic [5:0] EV_REL   = 6'b010000;
   localparam logic [5:0] EV_SHORT = 6'b001000;
   localparam logic [5:0] EV_LONG  = 6'b000100;
   localparam logic [5:0] EV_DBL   = 6'b000010;
   localparam logic [5:0] EV_HELD  = 6'b000001;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       short_click;
   logic       long_press;
   logic       double_click;
   logic       held;
   logic [5:0] click_count;

   logic [5:0] ev_s;
   logic [5:0] exp_cnt;
   int         n_cmp = 0;
   int         n_err = 0;
   int         n_clicks;

   always #5 clk = ~clk;

   btn_event_decoder #(
      .ACTIVE_LOW  (1'b1),
      .LONG_CYCLES (10),
      .GAP_CYCLES  (5),
      .CNT_W       (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .short_click   (short_click),
      .long_press    (long_press),
      .double_click  (double_click),
      .held          (held),
      .click_count   (click_count)
   );

   assign ev_s = {press_pulse, release_pulse, short_click, long_press, double_click, held};

   task automatic check(input string tag, input logic [5:0] exp_ev);
      n_cmp++;
      assert (ev_s === exp_ev) else begin
         n_err++;
         $error("FAIL %s events: observed %b expected %b", tag, ev_s, exp_ev);
      end
      n_cmp++;
      assert (click_count === exp_cnt) else begin
         n_err++;
         $error("FAIL %s click_count: observed %0d expected %0d", tag, click_count, exp_cnt);
      end
   endtask

   // One clock with the given level, then check the registered result
   task automatic step(input logic lvl, input string tag, input logic [5:0] exp_ev);
      btn_level = lvl;
      @(posedge clk);
      @(negedge clk);
      check(tag, exp_ev);
   endtask

   // Short press of two cycles, release, then six released cycles
   task automatic short_gesture(input string tag);
      step(1'b0, tag, EV_PRESS | EV_HELD);
      step(1'b0, tag, EV_HELD);
      if (!DC_EN) exp_cnt = exp_cnt + 6'd1;
      step(1'b1, tag, DC_EN ? EV_REL : (EV_REL | EV_SHORT));
      for (int j = 1; j <= 6; j++) begin
         if (DC_EN && j == 5) exp_cnt = exp_cnt + 6'd1;
         step(1'b1, tag, (DC_EN && j == 5) ? EV_SHORT : EV_NONE);
      end
   endtask

   initial begin
      rst       = 1'b1;
      btn_level = 1'b1;
      exp_cnt   = 6'd0;

      // 1: reset state, then idle after reset release
      @(negedge clk);
      @(negedge clk);
      check("reset", EV_NONE);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, "idle_after_rst", EV_NONE);

      // 2: press 4 cycles, release, 9 idle cycles
      step(1'b0, "t2_press", EV_PRESS | EV_HELD);
      for (int i = 0; i < 3; i++) step(1'b0, "t2_hold", EV_HELD);
      if (!DC_EN) exp_cnt = exp_cnt + 6'd1;
      step(1'b1, "t2_release", DC_EN ? EV_REL : (EV_REL | EV_SHORT));
      for (int j = 1; j <= 9; j++) begin
         if (DC_EN && j == 5) exp_cnt = exp_cnt + 6'd1;
         step(1'b1, "t2_gap", (DC_EN && j == 5) ? EV_SHORT : EV_NONE);
      end

      // 3: hold 15 cycles -> single long_press 10 cycles after press
      for (int k = 0; k < 15; k++) begin
         step(1'b0, "t3_hold", (k == 0) ? (EV_PRESS | EV_HELD) :
                               (k == 10) ? (EV_LONG | EV_HELD) : EV_HELD);
      end
      step(1'b1, "t3_release", EV_REL);
      for (int i = 0; i < 8; i++) step(1'b1, "t3_idle", EV_NONE);

      // 4: press 3, release 2, press 3, release
      step(1'b0, "t4_press1", EV_PRESS | EV_HELD);
      for (int i = 0; i < 2; i++) step(1'b0, "t4_hold1", EV_HELD);
      if (!DC_EN) exp_cnt = exp_cnt + 6'd1;
      step(1'b1, "t4_rel1", DC_EN ? EV_REL : (EV_REL | EV_SHORT));
      step(1'b1, "t4_gap", EV_NONE);
      step(1'b0, "t4_press2", DC_EN ? (EV_PRESS | EV_DBL | EV_HELD) : (EV_PRESS | EV_HELD));
      for (int i = 0; i < 2; i++) step(1'b0, "t4_hold2", EV_HELD);
      if (!DC_EN) exp_cnt = exp_cnt + 6'd1;
      step(1'b1, "t4_rel2", DC_EN ? EV_REL : (EV_REL | EV_SHORT));
      for (int i = 0; i < 8; i++) step(1'b1, "t4_idle", EV_NONE);

      // 5: short clicks until the counter wraps through 63 to 0
      n_clicks = 64 - int'(exp_cnt);
      for (int c = 0; c < n_clicks; c++) short_gesture("t5_click");
      n_cmp++;
      assert (click_count === 6'd0) else begin
         n_err++;
         $error("FAIL t5_wrap: observed %0d expected 0", click_count);
      end

      // 5b: reset while pressed clears outputs asynchronously
      short_gesture("t5_pre");
      step(1'b0, "t5_rst_press", EV_PRESS | EV_HELD);
      step(1'b0, "t5_rst_hold", EV_HELD);
      rst     = 1'b1;
      exp_cnt = 6'd0;
      #1;
      check("t5_async_rst", EV_NONE);
      btn_level = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1, "t5_after_rst", EV_NONE);

      // 5c: reset while waiting for a possible second click discards it
      step(1'b0, "t5g_press", EV_PRESS | EV_HELD);
      if (!DC_EN) exp_cnt = exp_cnt + 6'd1;
      step(1'b1, "t5g_rel", DC_EN ? EV_REL : (EV_REL | EV_SHORT));
      step(1'b1, "t5g_gap", EV_NONE);
      rst     = 1'b1;
      exp_cnt = 6'd0;
      #1;
      check("t5g_async_rst", EV_NONE);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b1, "t5g_after_rst", EV_NONE);

      // Button held through reset release gives press_pulse on first clock
      rst       = 1'b1;
      btn_level = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, "held_thru_rst", EV_PRESS | EV_HELD);
      if (!DC_EN) exp_cnt = exp_cnt + 6'd1;
      step(1'b1, "held_thru_rst_rel", DC_EN ? EV_REL : (EV_REL | EV_SHORT));
      for (int j = 1; j <= 6; j++) begin
         if (DC_EN && j == 5) exp_cnt = exp_cnt + 6'd1;
         step(1'b1, "held_thru_rst_gap", (DC_EN && j == 5) ? EV_SHORT : EV_NONE);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
